// File: rtl/platform_scroller.sv
// ---------------------------------------------------------------------------
// platform_scroller
//
// Keeps eight platforms in world coordinates for a vertical-scrolling game
// and advances the camera (viewTop) upward through the world on request.
// A scroll request moves the view by SCROLL_AMT pixels at a maximum of
// SCROLL_STEP pixels per video frame. When the view arrives, every platform
// that has fallen below the new view top is respawned above the highest
// platform, one slot per clock.
//
// Ports
//   clk        in   1   system clock, all state updates on the rising edge
//   reset      in   1   synchronous, active-high reset
//   newView    in   1   single-cycle scroll request
//   frameTick  in   1   single-cycle pulse once per video frame
//   rdIdx      in   3   platform slot selected for readout
//   rdX        out 32   world X of slot rdIdx
//   rdY        out 32   world Y of slot rdIdx
//   rdScreenY  out 32   rdY - viewTop, modulo 2^32
//   rdVisible  out  1   1 when viewTop <= rdY < viewTop + SCREEN_HEIGHT
//   viewTop    out 32   world Y of the top edge of the screen
//   busy       out  1   1 while a scroll or cull is in progress
//   scrollDone out  1   one-cycle pulse on the last cull cycle
// ---------------------------------------------------------------------------
module platform_scroller #(
   parameter int unsigned SCREEN_WIDTH  = 400,
   parameter int unsigned SCREEN_HEIGHT = 700,
   parameter int unsigned BLOCK_WIDTH   = 40,
   parameter int unsigned BLOCK_HEIGHT  = 5,
   parameter int unsigned SCROLL_STEP   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        newView,
   input  logic        frameTick,
   input  logic [2:0]  rdIdx,
   output logic [31:0] rdX,
   output logic [31:0] rdY,
   output logic [31:0] rdScreenY,
   output logic        rdVisible,
   output logic [31:0] viewTop,
   output logic        busy,
   output logic        scrollDone
);

   localparam int unsigned NUM_SLOTS = 8;

   localparam logic [31:0] SPAWN_GAP  = 32'(SCREEN_HEIGHT / 8);
   localparam logic [31:0] SCROLL_AMT = 32'(SCREEN_HEIGHT >> 2);
   localparam logic [31:0] X_RANGE    = 32'(SCREEN_WIDTH - BLOCK_WIDTH);
   localparam logic [31:0] STEP_MAX   = 32'(SCROLL_STEP);
   localparam logic [31:0] VIEW_SPAN  = 32'(SCREEN_HEIGHT);
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;

   // Elaboration-time sanity checks on the geometry parameters.
   if (BLOCK_WIDTH >= SCREEN_WIDTH) begin : gBadWidth
      $error("platform_scroller: BLOCK_WIDTH must be smaller than SCREEN_WIDTH");
   end
   if (BLOCK_HEIGHT == 0 || BLOCK_HEIGHT >= SCREEN_HEIGHT) begin : gBadHeight
      $error("platform_scroller: BLOCK_HEIGHT must be in 1..SCREEN_HEIGHT-1");
   end
   if (SCROLL_STEP == 0) begin : gBadStep
      $error("platform_scroller: SCROLL_STEP must be non-zero");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCROLL = 2'd1,
      CULL   = 2'd2
   } state_t;

   state_t state;
   state_t nextState;

   logic [31:0] slotX [NUM_SLOTS];
   logic [31:0] slotY [NUM_SLOTS];
   logic [31:0] highestY;
   logic [15:0] lfsr;
   logic [31:0] target;
   logic        pending;
   logic [2:0]  idx;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [31:0] remaining;
   logic [31:0] stepAmt;
   logic        atTarget;
   logic        startScroll;
   logic [15:0] lfsrNext;
   logic [31:0] lfsrLow;
   logic [31:0] spawnX;
   logic [31:0] spawnY;
   logic        cullHit;

   always_comb begin
      // Distance left to travel; the final frame takes only what remains so
      // the view lands exactly on target and never overshoots.
      remaining   = target - viewTop;
      stepAmt     = (remaining < STEP_MAX) ? remaining : STEP_MAX;
      atTarget    = (viewTop == target);
      startScroll = newView || pending;

      lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      // Fold the 9-bit random value into the range of legal left edges.
      // The current (pre-advance) LFSR value is used for the new platform.
      lfsrLow = {23'd0, lfsr[8:0]};
      spawnX  = (lfsrLow < X_RANGE) ? lfsrLow : (lfsrLow - X_RANGE);
      spawnY  = highestY + SPAWN_GAP;

      cullHit = (slotY[idx] < viewTop);
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking assignments so that all
   // registers sample their inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   // NOTE: nextState gets a default before the case so no path through the
   // block leaves it unassigned, which would infer a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (startScroll) begin
               nextState = SCROLL;
            end
         end
         SCROLL: begin
            if (atTarget) begin
               nextState = CULL;
            end
         end
         CULL: begin
            if (idx == 3'(NUM_SLOTS - 1)) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy       = (state != IDLE);
      scrollDone = (state == CULL) && (idx == 3'(NUM_SLOTS - 1));
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   // NOTE: the slot arrays sit in the reset branch on purpose: the starting
   // platform layout is part of the game state, so this is a register file
   // with reset values rather than a RAM, and it cannot map onto block RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         viewTop  <= '0;
         target   <= '0;
         pending  <= 1'b0;
         idx      <= '0;
         lfsr     <= LFSR_SEED;
         highestY <= SPAWN_GAP * 32'(NUM_SLOTS - 1);
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slotX[i] <= 32'(45 * i);
            slotY[i] <= SPAWN_GAP * 32'(i);
         end
      end else begin
         unique case (state)
            IDLE: begin
               // A request arriving now and one left over from the last busy
               // period are the same thing: start one scroll and drop both.
               if (startScroll) begin
                  target  <= viewTop + SCROLL_AMT;
                  pending <= 1'b0;
               end
            end

            SCROLL: begin
               if (newView) begin
                  pending <= 1'b1;
               end
               if (atTarget) begin
                  idx <= '0;
               end else if (frameTick) begin
                  viewTop <= viewTop + stepAmt;
               end
            end

            CULL: begin
               if (newView) begin
                  pending <= 1'b1;
               end
               if (cullHit) begin
                  slotX[idx] <= spawnX;
                  slotY[idx] <= spawnY;
                  highestY   <= spawnY;
                  lfsr       <= lfsrNext;
               end
               idx <= idx + 3'd1;
            end

            default: begin
               idx <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Readout port: purely combinational view of the register file
   // ------------------------------------------------------------------------
   always_comb begin
      rdX       = slotX[rdIdx];
      rdY       = slotY[rdIdx];
      rdScreenY = rdY - viewTop;
      rdVisible = (rdY >= viewTop) && (rdY < (viewTop + VIEW_SPAN));
   end

endmodule

// File: tb/tb_platform_scroller.sv
// ---------------------------------------------------------------------------
// tb_platform_scroller
//
// Directed bench for platform_scroller at default parameters. Inputs are
// driven 1 ns after each rising edge and outputs are sampled at that same
// point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_platform_scroller;

   logic        clk;
   logic        reset;
   logic        newView;
   logic        frameTick;
   logic [2:0]  rdIdx;
   logic [31:0] rdX;
   logic [31:0] rdY;
   logic [31:0] rdScreenY;
   logic        rdVisible;
   logic [31:0] viewTop;
   logic        busy;
   logic        scrollDone;

   int assertCount = 0;
   int failCount   = 0;
   int doneCount   = 0;
   int doneStart   = 0;

   platform_scroller dut (
      .clk        (clk),
      .reset      (reset),
      .newView    (newView),
      .frameTick  (frameTick),
      .rdIdx      (rdIdx),
      .rdX        (rdX),
      .rdY        (rdY),
      .rdScreenY  (rdScreenY),
      .rdVisible  (rdVisible),
      .viewTop    (viewTop),
      .busy       (busy),
      .scrollDone (scrollDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completion pulses mid-cycle, away from the edge that changes them.
   always @(negedge clk) begin
      if (scrollDone === 1'b1) begin
         doneCount <= doneCount + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                tag, observed, observed, expected, expected);
      end
   endtask

   task automatic readSlot(input logic [2:0] slot);
      rdIdx = slot;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      newView   = 1'b0;
      frameTick = 1'b0;
      rdIdx     = 3'd3;
      step(2);
      reset = 1'b0;

      // ---- Reset state ----------------------------------------------------
      check("rst_viewTop",    viewTop,    32'd0);
      check("rst_busy",       busy,       32'd0);
      check("rst_scrollDone", scrollDone, 32'd0);
      check("rst_s3_x",       rdX,        32'd135);
      check("rst_s3_y",       rdY,        32'd261);
      check("rst_s3_scrY",    rdScreenY,  32'd261);
      check("rst_s3_vis",     rdVisible,  32'd1);
      readSlot(3'd7);
      check("rst_s7_x",       rdX,        32'd315);
      check("rst_s7_y",       rdY,        32'd609);

      // ---- One full scroll with a frame tick every cycle -------------------
      newView = 1'b1;
      step(1);
      newView   = 1'b0;
      frameTick = 1'b1;
      doneStart = doneCount;
      check("sc_busy_start", busy,    32'd1);
      check("sc_view_start", viewTop, 32'd0);
      step(1);
      check("sc_view_t1",    viewTop, 32'd4);
      step(42);
      check("sc_view_t43",   viewTop, 32'd172);
      step(1);
      check("sc_view_t44",   viewTop, 32'd175);
      check("sc_busy_t44",   busy,    32'd1);
      step(1);
      check("sc_cull0_view", viewTop,    32'd175);
      check("sc_cull0_done", scrollDone, 32'd0);
      step(7);
      check("sc_cull7_done", scrollDone, 32'd1);
      step(1);
      frameTick = 1'b0;
      check("sc_end_busy",   busy,       32'd0);
      check("sc_end_done",   scrollDone, 32'd0);
      check("sc_end_view",   viewTop,    32'd175);
      check("sc_done_pulses", 32'(doneCount - doneStart), 32'd1);

      readSlot(3'd0);
      check("sc_s0_y",    rdY,       32'd696);
      check("sc_s0_x",    rdX,       32'd225);
      check("sc_s0_scrY", rdScreenY, 32'd521);
      check("sc_s0_vis",  rdVisible, 32'd1);
      readSlot(3'd1);
      check("sc_s1_y",    rdY,       32'd783);
      check("sc_s1_x",    rdX,       32'd91);
      readSlot(3'd2);
      check("sc_s2_y",    rdY,       32'd870);
      check("sc_s2_x",    rdX,       32'd31);
      check("sc_s2_vis",  rdVisible, 32'd1);
      readSlot(3'd3);
      check("sc_s3_y",    rdY,       32'd261);
      check("sc_s3_scrY", rdScreenY, 32'd86);
      check("sc_s3_vis",  rdVisible, 32'd1);
      readSlot(3'd4);
      check("sc_s4_y",    rdY,       32'd348);
      check("sc_s4_x",    rdX,       32'd180);

      // ---- Two requests during a scroll collapse into one more scroll ------
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      newView = 1'b1;
      step(1);
      newView   = 1'b0;
      frameTick = 1'b1;
      doneStart = doneCount;
      step(5);
      newView = 1'b1;
      step(1);
      newView = 1'b0;
      step(3);
      newView = 1'b1;
      step(1);
      newView = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (viewTop == 32'd350 && busy == 1'b0) break;
         step(1);
      end
      step(5);
      frameTick = 1'b0;
      check("pd_view",        viewTop, 32'd350);
      check("pd_busy",        busy,    32'd0);
      check("pd_done_pulses", 32'(doneCount - doneStart), 32'd2);
      readSlot(3'd3);
      check("pd_s3_y",    rdY,       32'd957);
      check("pd_s3_x",    rdX,       32'd271);
      readSlot(3'd4);
      check("pd_s4_y",    rdY,       32'd1044);
      check("pd_s4_x",    rdX,       32'd30);
      check("pd_s4_scrY", rdScreenY, 32'd694);
      check("pd_s4_vis",  rdVisible, 32'd1);
      readSlot(3'd5);
      check("pd_s5_y",    rdY,       32'd435);
      check("pd_s5_scrY", rdScreenY, 32'd85);

      // ---- No frame ticks: the view holds while the FSM waits --------------
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      newView = 1'b1;
      step(1);
      newView   = 1'b0;
      doneStart = doneCount;
      step(100);
      check("nt_view",  viewTop, 32'd0);
      check("nt_busy",  busy,    32'd1);
      check("nt_done",  32'(doneCount - doneStart), 32'd0);

      // ---- Reset in the middle of a scroll ---------------------------------
      frameTick = 1'b1;
      step(10);
      frameTick = 1'b0;
      check("mr_view40", viewTop, 32'd40);
      readSlot(3'd0);
      check("mr_s0_vis",  rdVisible, 32'd0);
      check("mr_s0_scrY", rdScreenY, 32'hFFFF_FFD8);
      readSlot(3'd1);
      check("mr_s1_vis",  rdVisible, 32'd1);
      // Leave a request pending, then reset with newView and frameTick high.
      newView = 1'b1;
      step(1);
      newView   = 1'b0;
      reset     = 1'b1;
      newView   = 1'b1;
      frameTick = 1'b1;
      step(1);
      reset     = 1'b0;
      newView   = 1'b0;
      frameTick = 1'b0;
      check("mr_view",  viewTop,    32'd0);
      check("mr_busy",  busy,       32'd0);
      check("mr_done",  scrollDone, 32'd0);
      readSlot(3'd0);
      check("mr_s0_y",  rdY, 32'd0);
      check("mr_s0_x",  rdX, 32'd0);
      readSlot(3'd7);
      check("mr_s7_y",  rdY, 32'd609);
      check("mr_s7_x",  rdX, 32'd315);
      step(5);
      check("mr_nopend_busy", busy,    32'd0);
      check("mr_nopend_view", viewTop, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
